// File: rtl/sync_level_filter_pkg.sv
// rtl/sync_level_filter_pkg.sv - shared helpers for the level synchronizer/filter
//
// Purpose : counter-width function and parameter legality predicates used by
//           sync_level_filter and sync_filter_chan.
// Ports   : none (package).
// Config  : SYNC_LEVEL_FILTER_EN selects the counter filter in sync_filter_chan.

package sync_level_filter_pkg;

   localparam int MIN_FLOP_NUM   = 2;
   localparam int MIN_FILTER_CNT = 1;

   // Bits needed to represent values 0 .. value-1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic bit flop_num_legal(input int flop_num);
      return flop_num >= MIN_FLOP_NUM;
   endfunction

   function automatic bit filter_cnt_legal(input int filter_cnt);
      return filter_cnt >= MIN_FILTER_CNT;
   endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// rtl/sync_filter_chan.sv - one channel: sync chain, stability filter, edge pulses
//
// Purpose : single-bit metastability chain followed by an optional stability
//           counter; commits a new level and emits a registered rise/fall pulse
//           in the same cycle the committed level changes.
// Ports   : clk        - destination clock
//           rst_b      - asynchronous active-low reset
//           sync_in    - asynchronous level input
//           sync_out   - synchronized, filtered level (resets to RST_VAL)
//           rise_pulse - one-cycle pulse when sync_out goes 0->1
//           fall_pulse - one-cycle pulse when sync_out goes 1->0
// Config  : SYNC_LEVEL_FILTER_EN defined   -> FILTER_CNT-cycle stability counter
//           SYNC_LEVEL_FILTER_EN undefined -> no counter, commit on any change

module sync_filter_chan
   import sync_level_filter_pkg::*;
#(
   parameter int   FLOP_NUM   = 3,
   parameter int   FILTER_CNT = 4,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst_b,
   input  logic sync_in,
   output logic sync_out,
   output logic rise_pulse,
   output logic fall_pulse
);

   if (!flop_num_legal(FLOP_NUM)) begin : g_bad_flop_num
      $error("sync_filter_chan: FLOP_NUM must be >= 2");
   end
   if (!filter_cnt_legal(FILTER_CNT)) begin : g_bad_filter_cnt
      $error("sync_filter_chan: FILTER_CNT must be >= 1");
   end

   logic [FLOP_NUM-1:0] ff_q, ff_d;
   logic                sync_out_q, sync_out_d;
   logic                rise_q, rise_d;
   logic                fall_q, fall_d;
   logic                chain_out;
   logic                commit;

   assign chain_out = ff_q[FLOP_NUM-1];

   always_comb begin
      ff_d = {ff_q[FLOP_NUM-2:0], sync_in};
   end

`ifdef SYNC_LEVEL_FILTER_EN
   localparam int                CNT_W    = clog2(FILTER_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CNT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count consecutive cycles the chain disagrees with the committed level;
   // any agreement (glitch ended) clears the count. Commit also clears it,
   // so the counter never passes CNT_LAST.
   always_comb begin
      cnt_d  = '0;
      commit = 1'b0;
      if (chain_out != sync_out_q) begin
         if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   always_comb begin
      commit = (chain_out != sync_out_q);
   end
`endif

   // Pulses are registered alongside the level so they line up with the
   // cycle in which sync_out shows the new value.
   always_comb begin
      sync_out_d = commit ? chain_out : sync_out_q;
      rise_d     = commit &  chain_out;
      fall_d     = commit & ~chain_out;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ff_q       <= {FLOP_NUM{RST_VAL}};
         sync_out_q <= RST_VAL;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
      end else begin
         ff_q       <= ff_d;
         sync_out_q <= sync_out_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
      end
   end

   assign sync_out   = sync_out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule

// File: rtl/sync_level_filter.sv
// rtl/sync_level_filter.sv - multi-channel level synchronizer with stability filter
//
// Purpose : brings SIGNAL_WIDTH independent asynchronous levels into the clk
//           domain, optionally rejecting pulses shorter than FILTER_CNT cycles,
//           and provides registered rise/fall pulses aligned with sync_out.
// Ports   : clk        - destination clock
//           rst_b      - asynchronous active-low reset
//           sync_in    - [SIGNAL_WIDTH] asynchronous levels
//           sync_out   - [SIGNAL_WIDTH] synchronized, filtered levels (reset RST_VAL)
//           rise_pulse - [SIGNAL_WIDTH] one-cycle 0->1 pulses (reset 0)
//           fall_pulse - [SIGNAL_WIDTH] one-cycle 1->0 pulses (reset 0)
// Config  : SYNC_LEVEL_FILTER_EN enables the per-channel stability counter.

module sync_level_filter
   import sync_level_filter_pkg::*;
#(
   parameter int                      SIGNAL_WIDTH = 1,
   parameter int                      FLOP_NUM     = 3,
   parameter int                      FILTER_CNT   = 4,
   parameter logic [SIGNAL_WIDTH-1:0] RST_VAL      = {SIGNAL_WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic [SIGNAL_WIDTH-1:0] sync_in,
   output logic [SIGNAL_WIDTH-1:0] sync_out,
   output logic [SIGNAL_WIDTH-1:0] rise_pulse,
   output logic [SIGNAL_WIDTH-1:0] fall_pulse
);

   for (genvar i = 0; i < SIGNAL_WIDTH; i++) begin : g_chan
      sync_filter_chan #(
         .FLOP_NUM   (FLOP_NUM),
         .FILTER_CNT (FILTER_CNT),
         .RST_VAL    (RST_VAL[i])
      ) u_chan (
         .clk        (clk),
         .rst_b      (rst_b),
         .sync_in    (sync_in[i]),
         .sync_out   (sync_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i])
      );
   end

endmodule

// File: tb/tb_sync_level_filter.sv
// tb/tb_sync_level_filter.sv - self-checking bench for sync_level_filter

module tb_sync_level_filter;

   localparam int             W  = 4;
   localparam int             FN = 3;
   localparam int             FC = 4;
   localparam logic [W-1:0]   RV = 4'b1010;
`ifdef SYNC_LEVEL_FILTER_EN
   localparam int             FE = FC;
`else
   localparam int             FE = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic [W-1:0] sync_in = 4'b1011;
   logic [W-1:0] sync_out, rise_pulse, fall_pulse;

   int n_chk = 0;
   int n_err = 0;
   int rise0 = 0;
   int fall0 = 0;

   typedef struct packed {
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state: shift history plus run length of the chain output.
   logic [W-1:0] m_ff [FN];
   logic [W-1:0] m_out;
   logic [W-1:0] m_prev;
   int           m_run [W];

   sync_level_filter #(
      .SIGNAL_WIDTH (W),
      .FLOP_NUM     (FN),
      .FILTER_CNT   (FC),
      .RST_VAL      (RV)
   ) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .sync_in    (sync_in),
      .sync_out   (sync_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A new level is committed once the chain output has held a value that
   // differs from the committed level for FE consecutive edges.
   task automatic model_step();
      exp_t         e;
      logic [W-1:0] co;
      e = '0;
      if (!rst_b) begin
         for (int i = 0; i < FN; i++) m_ff[i] = RV;
         m_out  = RV;
         m_prev = RV;
         for (int b = 0; b < W; b++) m_run[b] = 0;
      end else begin
         co = m_ff[FN-1];
         for (int b = 0; b < W; b++) begin
            m_run[b] = (co[b] == m_prev[b]) ? m_run[b] + 1 : 1;
            if (co[b] != m_out[b] && m_run[b] >= FE) begin
               e.rise[b] = co[b];
               e.fall[b] = ~co[b];
               m_out[b]  = co[b];
            end
         end
         m_prev = co;
         for (int i = FN - 1; i > 0; i--) m_ff[i] = m_ff[i-1];
         m_ff[0] = sync_in;
      end
      e.lvl = m_out;
      exp_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rise_pulse[0]) rise0++;
         if (fall_pulse[0]) fall0++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_level", sync_out, e.lvl);
            chk("sb_rise", rise_pulse, e.rise);
            chk("sb_fall", fall_pulse, e.fall);
         end
      end
   end

   task automatic set_in(input logic [W-1:0] v);
      @(negedge clk);
      #1 sync_in = v;
   endtask

   task automatic wait_change(input string tag, input int exp_n);
      logic [W-1:0] base;
      int           n;
      base = sync_out;
      n    = 0;
      do begin
         @(negedge clk);
         n++;
      end while (sync_out === base && n < 40);
      chk(tag, n, exp_n);
   endtask

   task automatic clear_counts();
      rise0 = 0;
      fall0 = 0;
   endtask

   task automatic pulse_test(input int width);
      clear_counts();
      set_in(4'b1011);
      repeat (width - 1) @(negedge clk);
      set_in(4'b1010);
      repeat (20) @(negedge clk);
      chk($sformatf("pulse%0d_rise", width), rise0, (width >= FE) ? 1 : 0);
      chk($sformatf("pulse%0d_fall", width), fall0, (width >= FE) ? 1 : 0);
   endtask

   initial begin
      // Reset with channel 0 held high: outputs sit at reset values.
      repeat (3) @(negedge clk);
      chk("rst_level", sync_out, RV);
      chk("rst_rise", rise_pulse, 0);
      chk("rst_fall", fall_pulse, 0);
      clear_counts();
      #1 rst_b = 1'b1;
      wait_change("rel_latency", FN + FE);
      chk("rel_level", sync_out, 4'b1011);
      repeat (3) @(negedge clk);
      chk("rel_rise_cnt", rise0, 1);
      chk("rel_fall_cnt", fall0, 0);

      // Held level changes: fall then rise then fall.
      clear_counts();
      set_in(4'b1010);
      wait_change("fall_latency", FN + FE);
      set_in(4'b1011);
      wait_change("rise_latency", FN + FE);
      repeat (10) @(negedge clk);
      set_in(4'b1010);
      wait_change("fall2_latency", FN + FE);
      repeat (3) @(negedge clk);
      chk("held_rise_cnt", rise0, 1);
      chk("held_fall_cnt", fall0, 2);

      // Pulse widths around the acceptance threshold.
      pulse_test(1);
      pulse_test(FC - 1);
      pulse_test(FC);

      // All channels flip at once.
      set_in(4'b0101);
      wait_change("multi_latency", FN + FE);
      chk("multi_level", sync_out, 4'b0101);
      chk("multi_rise", rise_pulse, 4'b0101);
      chk("multi_fall", fall_pulse, 4'b1010);
      set_in(RV);
      wait_change("multi_back", FN + FE);
      chk("multi_back_level", sync_out, RV);
      repeat (3) @(negedge clk);

      // Reset in the middle of a pending transition.
      clear_counts();
      set_in(4'b1011);
      repeat (5) @(negedge clk);
      chk("mid_rise_before", rise0, (FN + FE - 1 <= 4) ? 1 : 0);
      #1 rst_b = 1'b0;
      sync_in = RV;
      #1;
      chk("mid_rst_level", sync_out, RV);
      chk("mid_rst_rise", rise_pulse, 0);
      chk("mid_rst_fall", fall_pulse, 0);
      clear_counts();
      repeat (2) @(negedge clk);
      #1 rst_b = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_rise_after", rise0, 0);
      chk("mid_fall_after", fall0, 0);
      chk("mid_level_after", sync_out, RV);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
